// File: rtl/fpgame_vram_pkg.sv
// Shared VRAM definitions for the FPGAme write path: bus widths, region map,
// the packed write-entry layout and the write-buffer FSM states.
package fpgame_vram_pkg;

  localparam int VRAM_ADDR_W  = 13;
  localparam int VRAM_DATA_W  = 64;
  localparam int VRAM_BE_W    = 8;
  localparam int VRAM_ENTRY_W = VRAM_ADDR_W + VRAM_DATA_W + VRAM_BE_W;

  localparam logic [VRAM_ADDR_W-1:0] VRAM_TILE_BASE    = 13'h0000;
  localparam logic [VRAM_ADDR_W-1:0] VRAM_PATTERN_BASE = 13'h0800;
  localparam logic [VRAM_ADDR_W-1:0] VRAM_PALETTE_BASE = 13'h1800;
  localparam logic [VRAM_ADDR_W-1:0] VRAM_SPRITE_BASE  = 13'h1A00;
  localparam logic [VRAM_ADDR_W-1:0] VRAM_MAX_ADDR     = 13'h1A27;

  typedef enum logic {
    ST_HOLD  = 1'b0,
    ST_DRAIN = 1'b1
  } vram_wb_state_e;

  typedef struct packed {
    logic [VRAM_ADDR_W-1:0] addr;
    logic [VRAM_DATA_W-1:0] data;
    logic [VRAM_BE_W-1:0]   be;
  } vram_wr_entry_t;

  function automatic logic vram_addr_legal(input logic [VRAM_ADDR_W-1:0] addr,
                                           input logic [VRAM_ADDR_W-1:0] maxAddr);
    return addr <= maxAddr;
  endfunction

endpackage

// File: rtl/vram_wr_fifo.sv
// Synchronous FIFO of packed VRAM write entries with a look-ahead head output.
// Pushes while full and pops while empty are ignored.
module vram_wr_fifo
  import fpgame_vram_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  vram_wr_entry_t push_entry_i,
  input  logic           pop_i,
  output vram_wr_entry_t head_o,
  output logic           full_o,
  output logic           empty_o,
  output logic [CW-1:0]  count_o
);

  vram_wr_entry_t mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           do_push;
  logic           do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

endmodule

// File: rtl/vram_write_buffer.sv
// Buffers CPU VRAM writes and replays them to the PPU only inside the vblank
// window, one registered write strobe per popped entry.
module vram_write_buffer
  import fpgame_vram_pkg::*;
#(
  parameter  int                     DEPTH    = 16,
  parameter  logic [VRAM_ADDR_W-1:0] MAX_ADDR = VRAM_MAX_ADDR,
  localparam int                     CW       = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [VRAM_ADDR_W-1:0] wr_addr,
  input  logic [VRAM_DATA_W-1:0] wr_data,
  input  logic [VRAM_BE_W-1:0]   wr_byteena,
  input  logic                   vblank_start,
  input  logic                   vblank_end_soon,
  output logic [VRAM_ADDR_W-1:0] h2f_vram_wraddr,
  output logic                   h2f_vram_wren,
  output logic [VRAM_DATA_W-1:0] h2f_vram_wrdata,
  output logic [VRAM_BE_W-1:0]   h2f_vram_byteena,
  output logic                   cpu_vram_wr_irq,
  output logic                   cpu_wr_busy,
  output logic                   addr_err,
  output logic [CW-1:0]          fill_count
);

  vram_wb_state_e         state_q, state_d;
  vram_wr_entry_t         push_entry;
  vram_wr_entry_t         head;
  logic                   full;
  logic                   empty;
  logic                   accept;
  logic                   addr_ok;
  logic                   push;
  logic                   pop;
  logic                   irq_d, irq_q;
  logic                   err_d, err_q;
  logic                   wren_q;
  logic [VRAM_ADDR_W-1:0] addr_q;
  logic [VRAM_DATA_W-1:0] data_q;
  logic [VRAM_BE_W-1:0]   be_q;

  // Illegal and all-bytes-disabled requests are still handshaken, just dropped.
  assign wr_ready   = ~full;
  assign accept     = wr_valid & ~full;
  assign addr_ok    = vram_addr_legal(wr_addr, MAX_ADDR);
  assign push       = accept & addr_ok & (wr_byteena != '0);
  assign err_d      = err_q | (accept & ~addr_ok);
  assign push_entry = '{addr: wr_addr, data: wr_data, be: wr_byteena};

  vram_wr_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .full_o       (full),
    .empty_o      (empty),
    .count_o      (fill_count)
  );

  // A closing window takes priority over an opening one in the same cycle.
  always_comb begin
    state_d = state_q;
    irq_d   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      ST_HOLD: begin
        if (vblank_end_soon) begin
          state_d = ST_HOLD;
        end else if (vblank_start) begin
          state_d = ST_DRAIN;
          irq_d   = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (vblank_end_soon) begin
          state_d = ST_HOLD;
        end else begin
          pop = ~empty;
        end
      end
      default: state_d = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_HOLD;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
    end else begin
      state_q <= state_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
      wren_q  <= pop;
      if (pop) begin
        addr_q <= head.addr;
        data_q <= head.data;
        be_q   <= head.be;
      end
    end
  end

  assign h2f_vram_wraddr  = addr_q;
  assign h2f_vram_wren    = wren_q;
  assign h2f_vram_wrdata  = data_q;
  assign h2f_vram_byteena = be_q;
  assign cpu_vram_wr_irq  = irq_q;
  assign addr_err         = err_q;
  assign cpu_wr_busy      = (fill_count != '0) | wren_q;

endmodule
